// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit adder: one shared 4-bit carry-lookahead slice, one nibble per clock, LSB first.
// Optional subtract mode is enabled by defining SUB_EN (adds the 'sub' input port).
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             done,
  input  logic             ack,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [CW+1:0]    base;
  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic [3:0]       sl_g;
  logic [3:0]       sl_p;
  logic [4:0]       sl_c;
  logic [3:0]       sl_f;
  logic             op_sub;

`ifdef SUB_EN
  assign op_sub = sub;
`else
  assign op_sub = 1'b0;
`endif

  // Shared 4-bit carry-lookahead slice fed by the current nibble
  always_comb begin
    base    = {cnt, 2'b00};
    sl_a    = opa[base +: 4];
    sl_b    = opb[base +: 4];
    sl_g    = sl_a & sl_b;
    sl_p    = sl_a ^ sl_b;
    sl_c[0] = carry;
    sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
    sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
    sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
    sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
    sl_f    = sl_p ^ sl_c[3:0];
  end

  // Sequencer with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= op_sub ? ~b : b;
            carry <= op_sub ? 1'b1 : cin;
            cnt   <= '0;
            sum   <= '0;
            ready <= 1'b0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum[base +: 4] <= sl_f;
          carry          <= sl_c[4];
          if (cnt == LAST) begin
            cout  <= sl_c[4];
            ovf   <= (opa[WIDTH-1] == opb[WIDTH-1]) && (sl_f[3] != opa[WIDTH-1]);
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          // A simultaneous start is dropped; the requester re-asserts it in IDLE
          if (ack) begin
            done  <= 1'b0;
            ready <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
